// File: rtl/pwm_pkg.sv
// Types and defaults shared by the PWM output stage and its receive-side demodulator.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs; both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: aligns to frame-start falling edges and turns the high time of each
// 2**WIDTH-cycle frame into a sample, with lock tracking and off-boundary edge reporting.
module pwm_demod
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int LOCK_FRAMES = 2,
    parameter int INVERT      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic             locked,
    output logic             resync_err
);

    localparam logic [WIDTH-1:0] IDX_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] IDX_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] IDX_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   H_SAT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [3:0]       LOCK_TGT = LOCK_FRAMES[3:0];

    // Map the measured high time to a sample; H can reach 2**WIDTH, so both senses saturate.
    function automatic logic [WIDTH-1:0] decode(input logic [WIDTH:0] h);
        logic [WIDTH-1:0] res;
        if (INVERT != 0) begin
            if (h >= H_SAT) begin
                res = {WIDTH{1'b0}};
            end else begin
                res = IDX_MAX - h[WIDTH-1:0];
            end
        end else begin
            if (h >= H_SAT) begin
                res = IDX_MAX;
            end else begin
                res = h[WIDTH-1:0];
            end
        end
        return res;
    endfunction

    logic             s_s;
    logic             fall_s;
    logic [WIDTH:0]   h_s;
    logic [3:0]       lock_next_s;
    logic [WIDTH-1:0] sample_next_s;

    logic             p_r;
    pwm_state_e       state_r;
    logic [WIDTH-1:0] idx_r;
    logic [WIDTH:0]   hcnt_r;
    logic [3:0]       lock_cnt_r;
    logic [WIDTH-1:0] sample_r;
    logic             valid_r;
    logic             locked_r;
    logic             resync_r;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (s_s)
    );

    assign fall_s        = p_r & ~s_s;
    assign h_s           = hcnt_r + {{WIDTH{1'b0}}, s_s};
    assign sample_next_s = decode(h_s);
    assign lock_next_s   = (lock_cnt_r == 4'd15) ? 4'd15 : lock_cnt_r + 4'd1;

    // Frame tracking, high-time measurement and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r        <= 1'b0;
            state_r    <= IDLE;
            idx_r      <= IDX_ZERO;
            hcnt_r     <= {(WIDTH+1){1'b0}};
            lock_cnt_r <= 4'd0;
            sample_r   <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            locked_r   <= 1'b0;
            resync_r   <= 1'b0;
        end else begin
            p_r      <= s_s;
            valid_r  <= 1'b0;
            resync_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_r <= MEASURE;
                        idx_r   <= IDX_ONE;
                        hcnt_r  <= {(WIDTH+1){1'b0}};
                    end else if (idx_r == IDX_MAX) begin
                        // No edge for a whole frame: steady input, start measuring anyway
                        state_r <= MEASURE;
                        idx_r   <= IDX_ZERO;
                        hcnt_r  <= {(WIDTH+1){1'b0}};
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                MEASURE: begin
                    if (fall_s && (idx_r != IDX_ZERO)) begin
                        resync_r   <= 1'b1;
                        lock_cnt_r <= 4'd0;
                        locked_r   <= 1'b0;
                        idx_r      <= IDX_ONE;
                        hcnt_r     <= {(WIDTH+1){1'b0}};
                    end else if (idx_r == IDX_MAX) begin
                        sample_r   <= sample_next_s;
                        valid_r    <= 1'b1;
                        hcnt_r     <= {(WIDTH+1){1'b0}};
                        idx_r      <= IDX_ZERO;
                        lock_cnt_r <= lock_next_s;
                        if (lock_next_s >= LOCK_TGT) begin
                            locked_r <= 1'b1;
                        end else begin
                            locked_r <= locked_r;
                        end
                    end else begin
                        hcnt_r <= h_s;
                        idx_r  <= idx_r + IDX_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign sample_out   = sample_r;
    assign sample_valid = valid_r;
    assign locked       = locked_r;
    assign resync_err   = resync_r;

endmodule
